// File: rtl/dcm_clkgen_prog_if.sv
// Firmware request/status signals and the DCM_CLKGEN PROGEN/PROGDATA/PROGDONE
// port, bundled for dcm_clkgen_prog.
interface dcm_clkgen_prog_if;
  logic       start;
  logic [7:0] m_minus1;
  logic [7:0] d_minus1;
  logic       busy;
  logic       done;
  logic       err;
  logic       progen;
  logic       progdata;
  logic       progdone;

  // master is the firmware plus DCM side, slave is the controller
  modport master (
    output start, m_minus1, d_minus1, progdone,
    input  busy, done, err, progen, progdata
  );
  modport slave (
    input  start, m_minus1, d_minus1, progdone,
    output busy, done, err, progen, progdata
  );
endinterface

// File: rtl/dcm_clkgen_prog.sv
// Runtime M/D reprogramming of a Spartan-6 DCM_CLKGEN over its serial PROG port.
// PROGCLK is expected to be tied to clkin.
//
// state  | meaning
// IDLE   | waiting for start; captures M-1/D-1 and rejects M-1 == 0
// LOAD_D | progen high, shifting command 1,0 then D-1 LSB first (10 cycles)
// GAP_D  | progen low for 2 cycles
// LOAD_M | progen high, shifting command 1,1 then M-1 LSB first (10 cycles)
// GAP_M  | progen low for 2 cycles
// GO     | single progen pulse with progdata low; arms the timeout
// WAIT   | waiting for a fresh progdone rising edge or timeout
// FINISH | one-cycle done pulse with err reporting the outcome
module dcm_clkgen_prog #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic              clkin,
  input logic              rst,
  dcm_clkgen_prog_if.slave bus
);
  localparam int            TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLOAD = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_D, GAP_D, LOAD_M, GAP_M, GO, WAIT, FINISH
  } state_t;

  state_t        state;
  logic [7:0]    m_q;
  logic [7:0]    d_q;
  logic [3:0]    bitcnt;
  logic [TW-1:0] tcnt;
  logic          pd_q;
  logic          progen_q;
  logic          progdata_q;
  logic          busy_q;
  logic          done_q;
  logic          err_q;
  logic [9:0]    frame_d;
  logic [9:0]    frame_m;

  // Bit 0 is shifted out first; bit 0 of each frame is emitted on state entry.
  assign frame_d = {d_q, 2'b01};
  assign frame_m = {m_q, 2'b11};

  always_ff @(posedge clkin) begin
    if (rst) begin
      state      <= IDLE;
      m_q        <= '0;
      d_q        <= '0;
      bitcnt     <= '0;
      tcnt       <= '0;
      pd_q       <= 1'b0;
      progen_q   <= 1'b0;
      progdata_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pd_q <= bus.progdone;
      case (state)
        IDLE: begin
          if (bus.start) begin
            m_q <= bus.m_minus1;
            d_q <= bus.d_minus1;
            if (bus.m_minus1 == 8'd0) begin
              state  <= FINISH;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state      <= LOAD_D;
              busy_q     <= 1'b1;
              err_q      <= 1'b0;
              progen_q   <= 1'b1;
              progdata_q <= 1'b1;
              bitcnt     <= 4'd1;
            end
          end
        end
        LOAD_D: begin
          if (bitcnt == 4'd10) begin
            state      <= GAP_D;
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
            bitcnt     <= 4'd0;
          end else begin
            progdata_q <= frame_d[bitcnt];
            bitcnt     <= bitcnt + 4'd1;
          end
        end
        GAP_D: begin
          if (bitcnt == 4'd1) begin
            state      <= LOAD_M;
            progen_q   <= 1'b1;
            progdata_q <= 1'b1;
            bitcnt     <= 4'd1;
          end else begin
            bitcnt <= bitcnt + 4'd1;
          end
        end
        LOAD_M: begin
          if (bitcnt == 4'd10) begin
            state      <= GAP_M;
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
            bitcnt     <= 4'd0;
          end else begin
            progdata_q <= frame_m[bitcnt];
            bitcnt     <= bitcnt + 4'd1;
          end
        end
        GAP_M: begin
          if (bitcnt == 4'd1) begin
            state      <= GO;
            progen_q   <= 1'b1;
            progdata_q <= 1'b0;
            bitcnt     <= 4'd0;
          end else begin
            bitcnt <= bitcnt + 4'd1;
          end
        end
        GO: begin
          state    <= WAIT;
          progen_q <= 1'b0;
          tcnt     <= TLOAD;
        end
        WAIT: begin
          // A level already high on entry has pd_q set and cannot count.
          if (bus.progdone && !pd_q) begin
            state  <= FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b0;
          end else if (tcnt == '0) begin
            state  <= FINISH;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            err_q  <= 1'b1;
          end else begin
            tcnt <= tcnt - 1'b1;
          end
        end
        FINISH: begin
          state  <= IDLE;
          done_q <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          progen_q   <= 1'b0;
          progdata_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.progen   = progen_q;
  assign bus.progdata = progdata_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule
